pkt_rx: RTL and testbench
=========================

Name: pkt_rx

Overview:
- DUT-side packet receiver: deframes the byte stream arriving on rxd/rx_vld and checks length and parity.
- Good packets are committed into a byte FIFO; bad ones are rolled back.
- Committed packets are exposed to the CPU register port for pop-reads.
- Counterpart of the packet transmitter that drives the same rxd/rx_vld link.

Parameters:
- FIFO_DEPTH, 32, byte entries in receive FIFO (power of 2, >=17).
- MY_ADDR_RST, 4'h0, reset value of destination filter address.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rxd  in  8  packet byte.
- rx_vld  in  1  high for every byte of a packet, contiguous; low between packets.
- cs  in  1  CPU access strobe, one cycle per access.
- addr  in  8  CPU register address.
- rw  in  1  1=write, 0=read.
- din  in  8  CPU write data.
- dout  out  8  CPU read data, registered.
- pkt_avail  out  1  at least one committed byte in FIFO.
- err  out  1  sticky error flag (OR of STATUS error bits).

Behaviour:
- Frame format: header byte {dest[7:4], len[3:0]}, then len payload bytes (0..15), then parity byte.
- Parity byte = XOR of header and all payload bytes.
- Reset: FSM=IDLE, FIFO empty, all pointers 0, dout=0, pkt_avail=0, err=0, counters 0, MY_ADDR=MY_ADDR_RST, CTRL.en=1.
- FSM states: IDLE, PAYLOAD, PARITY, WAIT_END, DROP.
- IDLE, rx_vld=1:
  - Header is always written speculatively at wr_ptr; running XOR seeded with header.
  - Go to PAYLOAD if en, dest==MY_ADDR, free space >= len+1 and len>0.
  - If len==0, go to PARITY.
  - Otherwise go to DROP: dest mismatch increments drop_cnt only; no space sets STATUS.ovf.
- PAYLOAD: each rx_vld byte is written and XORed; after len bytes go to PARITY.
- PARITY: the rx_vld byte is compared to the running XOR; go to WAIT_END.
- WAIT_END, rx_vld=0:
  - Parity match: commit, i.e. commit_ptr <- wr_ptr; pkt_cnt++.
  - Mismatch: rollback, i.e. wr_ptr <- commit_ptr; set STATUS.perr; err_cnt++.
  - Then IDLE.
- WAIT_END, rx_vld=1: extra byte; rollback, set STATUS.lerr, go DROP.
- rx_vld low in PAYLOAD or PARITY: truncated packet; rollback, set STATUS.lerr, err_cnt++, go IDLE.
- DROP: wait for rx_vld=0, then IDLE. Nothing is written; any speculative bytes are rolled back.
- Commit and rollback take effect on the clock after rx_vld falls. A back-to-back packet may start in that same cycle; its header is written at the post-rollback wr_ptr.
- CPU reads only see committed data: rd_ptr never passes commit_ptr.
- Registers (read data appears on dout one cycle after cs & ~rw):
  - 0x00 STATUS, R: {3'b0, ovf, lerr, perr, empty, pkt_avail}. Writing 1 to bits[4:2] clears them.
  - 0x01 DATA, R: pops one committed byte. Read when empty returns 0x00 with no pop.
  - 0x02 PKT_CNT, R: 8-bit, saturates at 0xFF.
  - 0x03 ERR_CNT, R: 8-bit, saturates at 0xFF.
  - 0x04 CTRL, RW: bit0 en; bit1 clear counters (self-clearing); bits[7:4] MY_ADDR.
  - Unmapped addresses read 0x00; writes to them are ignored.
- Clearing en mid-packet does not affect the packet in progress. It applies from the next header.
- Simultaneous pop and commit in one cycle: both take effect; pointer arithmetic is modulo FIFO_DEPTH using an extra wrap bit.
- rst mid-packet: all state returns to reset values; remaining bytes are treated as a new frame only after rx_vld has been low for at least one cycle.

Optional Feature:
- PKT_RX_STATS_EN: adds 0x05 DROP_CNT (dest-filtered packets) and 0x06 MAX_LEN (largest committed len), both 8-bit saturating and cleared by CTRL bit1.
- Without it: 0x05 and 0x06 read 0x00, and the counters are not synthesized.

Decomposition:
- pkt_rx_pkg: register address localparams, STATUS/CTRL bit indices, FSM state enum, header field widths.
- Sub-module pkt_rx_fifo: single-clock byte FIFO with separate wr_ptr/commit_ptr/rd_ptr and commit/rollback inputs. The FSM and register file stay in pkt_rx.

Test Plan:
- Good packet: MY_ADDR=0, bytes 0x03,0x11,0x22,0x33, parity 0x03 -> pkt_avail=1, PKT_CNT=1; four DATA reads return 0x03,0x11,0x22,0x33; then STATUS.empty=1.
- Bad parity: same bytes with parity 0x00 -> FIFO stays empty, STATUS.perr=1, ERR_CNT=1, err=1. Writing 0x04 to STATUS clears perr and err.
- Truncation, then back-to-back recovery:
  - Header 0x05, two payload bytes, rx_vld drops -> lerr=1, nothing committed.
  - Immediately after, header 0x00 with parity 0x00 -> commits a single 0x00 byte.
- Dest filter: CTRL=0x51 (MY_ADDR=5), packet with header 0x32 -> dropped, PKT_CNT unchanged. With PKT_RX_STATS_EN, DROP_CNT=1.
- Overflow and wrap:
  - Fill with one 16-byte packet (header 0x0F, 15 payload bytes, parity); send another -> ovf=1, second packet dropped.
  - Pop 16 bytes, then resend -> accepted, data correct across pointer wrap.
- Reset mid-PAYLOAD -> all outputs at reset values; the next clean packet is received correctly.

Source files
------------

// File: rtl/pkt_rx_pkg.sv
// Shared pkt_rx definitions: register map, STATUS/CTRL bit positions, header layout, FSM states.
package pkt_rx_pkg;

  localparam int DEST_W = 4;
  localparam int LEN_W  = 4;

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [LEN_W-1:0]  len;
  } hdr_t;

  localparam logic [7:0] REG_STATUS   = 8'h00;
  localparam logic [7:0] REG_DATA     = 8'h01;
  localparam logic [7:0] REG_PKT_CNT  = 8'h02;
  localparam logic [7:0] REG_ERR_CNT  = 8'h03;
  localparam logic [7:0] REG_CTRL     = 8'h04;
  localparam logic [7:0] REG_DROP_CNT = 8'h05;
  localparam logic [7:0] REG_MAX_LEN  = 8'h06;

  localparam int ST_AVAIL = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_PERR  = 2;
  localparam int ST_LERR  = 3;
  localparam int ST_OVF   = 4;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_CLR      = 1;
  localparam int CTRL_ADDR_LSB = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAYLOAD,
    S_PARITY,
    S_WAIT_END,
    S_DROP
  } state_e;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pkt_rx_fifo.sv
// Byte FIFO with speculative write pointer: writes land past commit_ptr until commit/rollback.
// Reads never pass commit_ptr; one slot is held back so a speculative header always has room.
module pkt_rx_fifo #(
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [7:0]    wr_dat_i,
  input  logic          commit_i,
  input  logic          rollback_i,
  input  logic          rd_en_i,
  output logic [7:0]    rd_dat_o,
  output logic [PW-1:0] avail_o,
  output logic [PW-1:0] free_o
);

  localparam logic [PW-1:0] CAP = PW'(DEPTH - 1);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  assign avail_o  = commit_ptr_q - rd_ptr_q;
  assign free_o   = CAP - (wr_ptr_q - rd_ptr_q);
  assign rd_dat_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    if (rollback_i) begin
      wr_ptr_d = commit_ptr_q;
    end else if (wr_en_i) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (commit_i) begin
      commit_ptr_d = wr_ptr_q;
    end
    if (rd_en_i && (avail_o != '0)) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i && !rollback_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
    end
  end

endmodule

// File: rtl/pkt_rx.sv
// Packet receiver: deframes rxd/rx_vld, checks len/parity, commits good frames to a FIFO popped via CPU regs; no rx backpressure
// (unfit frames are dropped), dout registered one cycle after cs. PKT_RX_STATS_EN adds DROP_CNT and MAX_LEN registers.
module pkt_rx
  import pkt_rx_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 32,
  parameter logic [3:0] MY_ADDR_RST = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rxd,
  input  logic       rx_vld,
  input  logic       cs,
  input  logic [7:0] addr,
  input  logic       rw,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       pkt_avail,
  output logic       err
);

  localparam int PW = $clog2(FIFO_DEPTH) + 1;

  state_e        state_q, state_d;
  hdr_t          hdr;
  logic [3:0]    len_q, len_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    xor_q, xor_d;
  logic          vld_q;
  logic          en_q;
  logic [3:0]    my_addr_q;
  logic          ovf_q, lerr_q, perr_q;
  logic [7:0]    pkt_cnt_q, err_cnt_q, dout_q;
  logic [PW-1:0] need;

  logic          wr_en, commit, rollback;
  logic          set_ovf, set_lerr, set_perr, inc_pkt, inc_err;
  logic [7:0]    fifo_dat;
  logic [PW-1:0] fifo_avail, fifo_free;

  logic          rd_acc, wr_acc, pop, sts_wr, ctrl_wr, clr_cnt;
  logic [7:0]    status, rd_val;

`ifdef PKT_RX_STATS_EN
  logic          inc_drop;
  logic [7:0]    drop_cnt_q, max_len_q;
`endif

  assign hdr = hdr_t'(rxd);

  pkt_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_dat_i  (rxd),
    .commit_i  (commit),
    .rollback_i(rollback),
    .rd_en_i   (pop),
    .rd_dat_o  (fifo_dat),
    .avail_o   (fifo_avail),
    .free_o    (fifo_free)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    xor_d    = xor_q;
    wr_en    = 1'b0;
    commit   = 1'b0;
    rollback = 1'b0;
    set_ovf  = 1'b0;
    set_lerr = 1'b0;
    set_perr = 1'b0;
    inc_pkt  = 1'b0;
    inc_err  = 1'b0;
`ifdef PKT_RX_STATS_EN
    inc_drop = 1'b0;
`endif
    need     = PW'(hdr.len) + PW'(1);
    case (state_q)
      S_IDLE: begin
        if (rx_vld) begin
          // vld_q high here only after reset: the tail of a cut frame
          if (vld_q) begin
            state_d = S_DROP;
          end else begin
            wr_en = 1'b1;
            xor_d = rxd;
            len_d = hdr.len;
            cnt_d = '0;
            if (!en_q) begin
              state_d = S_DROP;
            end else if (hdr.dest != my_addr_q) begin
              state_d = S_DROP;
`ifdef PKT_RX_STATS_EN
              inc_drop = 1'b1;
`endif
            end else if (fifo_free < need) begin
              state_d = S_DROP;
              set_ovf = 1'b1;
            end else if (hdr.len != '0) begin
              state_d = S_PAYLOAD;
            end else begin
              state_d = S_PARITY;
            end
          end
        end
      end
      S_PAYLOAD: begin
        if (rx_vld) begin
          wr_en = 1'b1;
          xor_d = xor_q ^ rxd;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q + 4'd1 == len_q) state_d = S_PARITY;
        end else begin
          rollback = 1'b1;
          set_lerr = 1'b1;
          inc_err  = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_PARITY: begin
        // folding the parity byte in leaves zero on a match
        if (rx_vld) begin
          xor_d   = xor_q ^ rxd;
          state_d = S_WAIT_END;
        end else begin
          rollback = 1'b1;
          set_lerr = 1'b1;
          inc_err  = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_WAIT_END: begin
        if (rx_vld) begin
          rollback = 1'b1;
          set_lerr = 1'b1;
          state_d  = S_DROP;
        end else if (xor_q == 8'h00) begin
          commit  = 1'b1;
          inc_pkt = 1'b1;
          state_d = S_IDLE;
        end else begin
          rollback = 1'b1;
          set_perr = 1'b1;
          inc_err  = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_DROP: begin
        rollback = 1'b1;
        if (!rx_vld) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      xor_q   <= '0;
      vld_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      xor_q   <= xor_d;
      vld_q   <= rx_vld;
    end
  end

  assign rd_acc    = cs && !rw;
  assign wr_acc    = cs && rw;
  assign pkt_avail = (fifo_avail != '0);
  assign pop       = rd_acc && (addr == REG_DATA) && pkt_avail;
  assign sts_wr    = wr_acc && (addr == REG_STATUS);
  assign ctrl_wr   = wr_acc && (addr == REG_CTRL);
  assign clr_cnt   = ctrl_wr && din[CTRL_CLR];
  assign status    = {3'b000, ovf_q, lerr_q, perr_q, !pkt_avail, pkt_avail};
  assign err       = ovf_q || lerr_q || perr_q;
  assign dout      = dout_q;

  always_comb begin
    rd_val = 8'h00;
    case (addr)
      REG_STATUS:   rd_val = status;
      REG_DATA:     rd_val = pkt_avail ? fifo_dat : 8'h00;
      REG_PKT_CNT:  rd_val = pkt_cnt_q;
      REG_ERR_CNT:  rd_val = err_cnt_q;
      REG_CTRL:     rd_val = {my_addr_q, 3'b000, en_q};
`ifdef PKT_RX_STATS_EN
      REG_DROP_CNT: rd_val = drop_cnt_q;
      REG_MAX_LEN:  rd_val = max_len_q;
`endif
      default:      rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q    <= 8'h00;
      en_q      <= 1'b1;
      my_addr_q <= MY_ADDR_RST;
      ovf_q     <= 1'b0;
      lerr_q    <= 1'b0;
      perr_q    <= 1'b0;
      pkt_cnt_q <= 8'h00;
      err_cnt_q <= 8'h00;
    end else begin
      if (rd_acc) dout_q <= rd_val;
      if (ctrl_wr) begin
        en_q      <= din[CTRL_EN];
        my_addr_q <= din[CTRL_ADDR_LSB +: 4];
      end
      if (set_ovf) ovf_q <= 1'b1;
      else if (sts_wr && din[ST_OVF]) ovf_q <= 1'b0;
      if (set_lerr) lerr_q <= 1'b1;
      else if (sts_wr && din[ST_LERR]) lerr_q <= 1'b0;
      if (set_perr) perr_q <= 1'b1;
      else if (sts_wr && din[ST_PERR]) perr_q <= 1'b0;
      if (clr_cnt) pkt_cnt_q <= 8'h00;
      else if (inc_pkt) pkt_cnt_q <= sat_inc(pkt_cnt_q);
      if (clr_cnt) err_cnt_q <= 8'h00;
      else if (inc_err) err_cnt_q <= sat_inc(err_cnt_q);
    end
  end

`ifdef PKT_RX_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= 8'h00;
      max_len_q  <= 8'h00;
    end else begin
      if (clr_cnt) drop_cnt_q <= 8'h00;
      else if (inc_drop) drop_cnt_q <= sat_inc(drop_cnt_q);
      if (clr_cnt) max_len_q <= 8'h00;
      else if (commit && ({4'h0, len_q} > max_len_q)) max_len_q <= {4'h0, len_q};
    end
  end
`endif

endmodule

// File: tb/tb_pkt_rx.sv
// Bench for pkt_rx: directed scenarios plus randomized frames against a queue-based reference model.
module tb_pkt_rx;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst, rx_vld, cs, rw;
  logic [7:0] rxd, addr, din, dout;
  logic       pkt_avail, err;

  always #5 clk = ~clk;

  pkt_rx dut (
    .clk(clk), .rst(rst), .rxd(rxd), .rx_vld(rx_vld), .cs(cs), .addr(addr),
    .rw(rw), .din(din), .dout(dout), .pkt_avail(pkt_avail), .err(err)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h, expected 0x%02h", nm, act, exp);
  endtask

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  string      nm_q[$];
  logic       rd_seen = 1'b0;

  always @(posedge clk) rd_seen <= cs && !rw && !rst;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_underflow: read returned 0x%02h with nothing expected", dout);
      end else begin
        check(nm_q.pop_front(), dout, exp_q.pop_front());
      end
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] m_fifo[$];
  int         m_pkt, m_err, m_drop, m_max;
  bit         m_ovf, m_lerr, m_perr, m_en;
  logic [3:0] m_addr;

  function automatic void m_reset();
    m_fifo.delete();
    m_pkt = 0; m_err = 0; m_drop = 0; m_max = 0;
    m_ovf = 0; m_lerr = 0; m_perr = 0; m_en = 1; m_addr = 4'h0;
  endfunction

  function automatic logic [7:0] sat(input int v);
    return (v > 255) ? 8'hFF : 8'(v);
  endfunction

  function automatic logic [7:0] xr(input bq_t b);
    logic [7:0] x = 8'h00;
    foreach (b[i]) x ^= b[i];
    return x;
  endfunction

  function automatic void m_apply(input bq_t b);
    int         n = b.size();
    logic [3:0] dest = b[0][7:4];
    int         len = int'(b[0][3:0]);
    if (!m_en) return;
    if (dest != m_addr) begin m_drop++; return; end
    if (31 - m_fifo.size() < len + 1) begin m_ovf = 1; return; end
    if (n < len + 2) begin m_lerr = 1; m_err++; return; end
    if (n > len + 2) begin m_lerr = 1; return; end
    if (xr(b) != 8'h00) begin m_perr = 1; m_err++; return; end
    for (int i = 0; i <= len; i++) m_fifo.push_back(b[i]);
    m_pkt++;
    if (len > m_max) m_max = len;
  endfunction

  function automatic logic [7:0] m_read(input logic [7:0] a);
    case (a)
      8'h00: return {3'b000, m_ovf, m_lerr, m_perr, m_fifo.size() == 0, m_fifo.size() != 0};
      8'h01: return (m_fifo.size() != 0) ? m_fifo.pop_front() : 8'h00;
      8'h02: return sat(m_pkt);
      8'h03: return sat(m_err);
      8'h04: return {m_addr, 3'b000, m_en};
`ifdef PKT_RX_STATS_EN
      8'h05: return sat(m_drop);
      8'h06: return sat(m_max);
`endif
      default: return 8'h00;
    endcase
  endfunction

  function automatic void m_write(input logic [7:0] a, input logic [7:0] d);
    if (a == 8'h00) begin
      if (d[4]) m_ovf = 0;
      if (d[3]) m_lerr = 0;
      if (d[2]) m_perr = 0;
    end else if (a == 8'h04) begin
      m_en = d[0];
      m_addr = d[7:4];
      if (d[1]) begin m_pkt = 0; m_err = 0; m_drop = 0; m_max = 0; end
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cpu_rd(input logic [7:0] a, input logic [7:0] e, input string nm);
    cs = 1'b1; rw = 1'b0; addr = a;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic rd_reg(input logic [7:0] a);
    cpu_rd(a, m_read(a), $sformatf("rd_%02h", a));
  endtask

  task automatic rd_lit(input logic [7:0] a, input logic [7:0] e, input string nm);
    if (a == 8'h01 && m_fifo.size() != 0) void'(m_fifo.pop_front());
    cpu_rd(a, e, nm);
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
    cs = 1'b1; rw = 1'b1; addr = a; din = d;
    @(negedge clk);
    cs = 1'b0; rw = 1'b0;
    m_write(a, d);
  endtask

  task automatic send(input bq_t b, input int gap);
    foreach (b[i]) begin
      rxd = b[i]; rx_vld = 1'b1;
      @(negedge clk);
    end
    rx_vld = 1'b0; rxd = 8'($urandom);
    repeat (gap) @(negedge clk);
    m_apply(b);
  endtask

  function automatic bq_t mk(input logic [3:0] dest, input logic [3:0] len, input logic [7:0] base);
    bq_t p;
    p.push_back({dest, len});
    for (int i = 0; i < int'(len); i++) p.push_back(base + 8'(i));
    p.push_back(xr(p));
    return p;
  endfunction

  task automatic chk_pins(input string tag);
    check({tag, "_pkt_avail"}, {7'b0, pkt_avail}, {7'b0, m_fifo.size() != 0});
    check({tag, "_err"}, {7'b0, err}, {7'b0, m_ovf | m_lerr | m_perr});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  logic [7:0] ra[11] = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h9C};

  initial begin
    bq_t p, p16;
    rst = 1'b1; rx_vld = 1'b0; rxd = 8'h00; cs = 1'b0; rw = 1'b0; addr = 8'h00; din = 8'h00;
    m_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_pkt_avail", {7'b0, pkt_avail}, 8'h00);
    check("rst_err", {7'b0, err}, 8'h00);
    check("rst_dout", dout, 8'h00);
    rd_lit(8'h00, 8'h02, "rst_status");
    rd_lit(8'h04, 8'h01, "rst_ctrl");
    rd_lit(8'h02, 8'h00, "rst_pkt_cnt");

    // good packet
    p = {8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    send(p, 1);
    check("good_pkt_avail", {7'b0, pkt_avail}, 8'h01);
    rd_lit(8'h02, 8'h01, "good_pkt_cnt");
    rd_lit(8'h01, 8'h03, "good_d0");
    rd_lit(8'h01, 8'h11, "good_d1");
    rd_lit(8'h01, 8'h22, "good_d2");
    rd_lit(8'h01, 8'h33, "good_d3");
    rd_lit(8'h00, 8'h02, "good_status_empty");

    // bad parity
    p = {8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
    send(p, 1);
    rd_lit(8'h00, 8'h06, "perr_status");
    rd_lit(8'h03, 8'h01, "perr_err_cnt");
    check("perr_err_pin", {7'b0, err}, 8'h01);
    wr_reg(8'h00, 8'h04);
    check("perr_clr_err_pin", {7'b0, err}, 8'h00);

    // truncation followed by back-to-back zero-length frame
    p = {8'h05, 8'hAA, 8'hBB};
    send(p, 1);
    p = {8'h00, 8'h00};
    send(p, 1);
    rd_lit(8'h00, 8'h09, "trunc_status");
    rd_lit(8'h03, 8'h02, "trunc_err_cnt");
    rd_lit(8'h02, 8'h02, "b2b_pkt_cnt");
    rd_lit(8'h01, 8'h00, "b2b_data");
    rd_lit(8'h00, 8'h0A, "b2b_status_empty");
    wr_reg(8'h00, 8'h08);

    // destination filter
    wr_reg(8'h04, 8'h51);
    p = {8'h32, 8'h01, 8'h02, 8'h31};
    send(p, 2);
    rd_lit(8'h02, 8'h02, "dest_pkt_cnt");
    rd_lit(8'h04, 8'h51, "dest_ctrl");
`ifdef PKT_RX_STATS_EN
    rd_lit(8'h05, 8'h01, "dest_drop_cnt");
`else
    rd_lit(8'h05, 8'h00, "dest_drop_cnt");
`endif
    wr_reg(8'h04, 8'h01);

    // overflow, then wrap
    p16 = mk(4'h0, 4'hF, 8'h40);
    send(p16, 1);
    send(p16, 1);
    rd_lit(8'h00, 8'h11, "ovf_status");
    rd_lit(8'h02, 8'h03, "ovf_pkt_cnt");
    for (int i = 0; i < 16; i++) rd_lit(8'h01, p16[i], $sformatf("ovf_d%0d", i));
    wr_reg(8'h00, 8'h10);
    p16 = mk(4'h0, 4'hF, 8'h80);
    send(p16, 1);
    rd_lit(8'h02, 8'h04, "wrap_pkt_cnt");
    for (int i = 0; i < 16; i++) rd_lit(8'h01, p16[i], $sformatf("wrap_d%0d", i));
    rd_lit(8'h00, 8'h02, "wrap_status");

    // randomized traffic
    for (int it = 0; it < 80; it++) begin
      logic [3:0] dest, len;
      int         mode, keep;
      if ($urandom_range(0, 9) == 0)
        wr_reg(8'h04, {4'($urandom_range(0, 2)), 2'b00, 1'($urandom_range(0, 4) == 0),
                       1'($urandom_range(0, 3) != 0)});
      dest = ($urandom_range(0, 3) == 0) ? 4'($urandom) : m_addr;
      len  = 4'($urandom_range(0, 15));
      mode = $urandom_range(0, 9);
      p = mk(dest, len, 8'($urandom));
      if (mode == 6) p[p.size()-1] = p[p.size()-1] ^ 8'($urandom_range(1, 255));
      if (mode == 7) begin
        keep = $urandom_range(1, int'(len) + 1);
        while (p.size() > keep) void'(p.pop_back());
      end
      if (mode == 8) p.push_back(8'($urandom));
      send(p, $urandom_range(1, 3));
      chk_pins($sformatf("rnd%0d", it));
      repeat ($urandom_range(0, 3)) rd_reg(ra[$urandom_range(0, 10)]);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 20)) rd_reg(8'h01);
      if ($urandom_range(0, 5) == 0) wr_reg(8'h00, 8'h1C);
    end
    rd_reg(8'h02);
    rd_reg(8'h03);
    rd_reg(8'h06);

    // reset in the middle of a payload
    wr_reg(8'h04, 8'h01);
    p = mk(4'h0, 4'h6, 8'h20);
    for (int i = 0; i < 3; i++) begin rxd = p[i]; rx_vld = 1'b1; @(negedge clk); end
    rst = 1'b1;
    for (int i = 3; i < 5; i++) begin rxd = p[i]; @(negedge clk); end
    rst = 1'b0;
    m_reset();
    check("mid_rst_pkt_avail", {7'b0, pkt_avail}, 8'h00);
    check("mid_rst_err", {7'b0, err}, 8'h00);
    check("mid_rst_dout", dout, 8'h00);
    for (int i = 5; i < p.size(); i++) begin rxd = p[i]; @(negedge clk); end
    rx_vld = 1'b0;
    @(negedge clk);
    rd_lit(8'h00, 8'h02, "post_rst_status");
    rd_lit(8'h02, 8'h00, "post_rst_pkt_cnt");
    rd_lit(8'h04, 8'h01, "post_rst_ctrl");
    p = {8'h02, 8'hA5, 8'h5A, 8'hFD};
    send(p, 1);
    rd_lit(8'h02, 8'h01, "clean_pkt_cnt");
    rd_lit(8'h01, 8'h02, "clean_d0");
    rd_lit(8'h01, 8'hA5, "clean_d1");
    rd_lit(8'h01, 8'h5A, "clean_d2");
    rd_lit(8'h00, 8'h02, "clean_status");

    repeat (3) @(negedge clk);
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL sb_drain: %0d reads outstanding, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
